// File: rtl/rv32i_pkg.sv
// Shared encodings for the multi-cycle RV32I control slice: opcodes, opcode
// classes, datapath select codes, mcause values and small address helpers.
package rv32i_pkg;

  // Base RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  // Opcode class registered in DECODE; FENCE maps onto CLS_NOP
  localparam logic [3:0] CLS_NOP    = 4'd0;
  localparam logic [3:0] CLS_ALU_R  = 4'd1;
  localparam logic [3:0] CLS_ALU_I  = 4'd2;
  localparam logic [3:0] CLS_LOAD   = 4'd3;
  localparam logic [3:0] CLS_STORE  = 4'd4;
  localparam logic [3:0] CLS_BRANCH = 4'd5;
  localparam logic [3:0] CLS_JAL    = 4'd6;
  localparam logic [3:0] CLS_JALR   = 4'd7;
  localparam logic [3:0] CLS_LUI    = 4'd8;
  localparam logic [3:0] CLS_AUIPC  = 4'd9;
  localparam logic [3:0] CLS_SYSTEM = 4'd10;

  // PC source
  localparam logic [1:0] PC_SEL_PC4    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JALR   = 2'd2;
  localparam logic [1:0] PC_SEL_TRAP   = 2'd3;

  // Register write-back source
  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;

  // ALU operation
  localparam logic [1:0] ALU_OP_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP_BRANCH = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'd2;

  // ALU operand sources (src_b code 2 selects the constant 4; unused here
  // because the link value comes from the PC+4 write-back path)
  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;
  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;

  // mcause exception codes
  localparam logic [3:0] CAUSE_FETCH_FAULT    = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT     = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT    = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;

  // Access misaligned for its size (funct3[1:0]: 0 byte, 1 half, 2 word)
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3[1:0])
      2'd0:    mis = 1'b0;
      2'd1:    mis = addr_lo[0];
      2'd2:    mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte strobes for a store; shifted bits past lane 3 are dropped
  function automatic logic [3:0] store_strobe(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (funct3[1:0])
      2'd0:    strb = 4'b0001 << addr_lo;
      2'd1:    strb = 4'b0011 << addr_lo;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/rv32i_op_decode.sv
// Combinational opcode classifier: maps opcode/funct3/funct7_5 onto an
// opcode class and flags encodings that are not legal RV32I.
module rv32i_op_decode
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] op_class,
  output logic       illegal
);

  // Class lookup plus funct3/funct7_5 legality per opcode
  always_comb begin
    op_class = CLS_NOP;
    illegal  = 1'b0;
    case (opcode)
      OPC_OP: begin
        op_class = CLS_ALU_R;
        illegal  = funct7_5 && (funct3 != 3'd0) && (funct3 != 3'd5);
      end
      OPC_OP_IMM: begin
        op_class = CLS_ALU_I;
        illegal  = funct7_5 && (funct3 == 3'd1);
      end
      OPC_LOAD: begin
        op_class = CLS_LOAD;
        illegal  = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        op_class = CLS_STORE;
        illegal  = (funct3 > 3'd2);
      end
      OPC_BRANCH: begin
        op_class = CLS_BRANCH;
        illegal  = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_JAL: begin
        op_class = CLS_JAL;
        illegal  = 1'b0;
      end
      OPC_JALR: begin
        op_class = CLS_JALR;
        illegal  = (funct3 != 3'd0);
      end
      OPC_LUI: begin
        op_class = CLS_LUI;
        illegal  = 1'b0;
      end
      OPC_AUIPC: begin
        op_class = CLS_AUIPC;
        illegal  = 1'b0;
      end
      OPC_FENCE: begin
        op_class = CLS_NOP;
        illegal  = (funct3 != 3'd0);
      end
      OPC_SYSTEM: begin
        // Only ECALL/EBREAK are supported; CSR forms are illegal
        op_class = CLS_SYSTEM;
        illegal  = (funct3 != 3'd0);
      end
      default: begin
        op_class = CLS_NOP;
        illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP with a
// req/ready memory handshake, byte strobes, load sign control, traps and
// a memory wait timeout. Outputs decode the registered state and class.
module rv32i_multicycle_control
  import rv32i_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT   = 16,
  parameter bit          MISALIGN_TRAP = 1'b1,
  parameter bit          TRAP_HALT     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       imm_sys,
  input  logic [1:0] addr_lo,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic [3:0] mem_wstrb,
  output logic [1:0] load_size,
  output logic       load_unsigned,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       trap,
  output logic [3:0] trap_cause
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  localparam int unsigned       CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [2:0]       state_r, state_nx_s;
  logic [3:0]       class_r;
  logic [3:0]       cause_r, cause_nx_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [3:0]       dec_class_s;
  logic             dec_illegal_s;
  logic             fetch_req_s, fetch_done_s, waiting_s, timeout_s, misalign_s, is_load_s;
  logic [1:0]       alu_a_s, alu_b_s, alu_op_s;

  rv32i_op_decode u_op_decode (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .op_class (dec_class_s),
    .illegal  (dec_illegal_s)
  );

  // A fetch is requested only while run is high and reset is not asserted,
  // so a ready arriving during reset can never be accepted.
  assign fetch_req_s  = run & ~rst;
  assign fetch_done_s = fetch_req_s & mem_ready;
  assign waiting_s    = ((state_r == ST_FETCH) & fetch_req_s & ~mem_ready) |
                        ((state_r == ST_MEM) & ~mem_ready);
  assign timeout_s    = (MEM_TIMEOUT != 0) & waiting_s & (wait_cnt_r == CNT_LAST);
  assign misalign_s   = MISALIGN_TRAP & is_misaligned(funct3, addr_lo);
  assign is_load_s    = (class_r == CLS_LOAD);

  // ALU operand/operation selects for the registered class
  always_comb begin
    alu_a_s  = SRC_A_RS1;
    alu_b_s  = SRC_B_RS2;
    alu_op_s = ALU_OP_ADD;
    case (class_r)
      CLS_ALU_R:  alu_op_s = ALU_OP_FUNCT;
      CLS_ALU_I:  begin alu_b_s = SRC_B_IMM; alu_op_s = ALU_OP_FUNCT; end
      CLS_LOAD,
      CLS_STORE,
      CLS_JALR:   alu_b_s = SRC_B_IMM;
      CLS_BRANCH: alu_op_s = ALU_OP_BRANCH;
      CLS_JAL,
      CLS_AUIPC:  begin alu_a_s = SRC_A_PC; alu_b_s = SRC_B_IMM; end
      CLS_LUI:    begin alu_a_s = SRC_A_ZERO; alu_b_s = SRC_B_IMM; end
      default:    alu_op_s = ALU_OP_ADD;
    endcase
  end

  // Next-state and trap cause selection
  always_comb begin
    state_nx_s = state_r;
    cause_nx_s = cause_r;
    case (state_r)
      ST_FETCH: begin
        if (timeout_s) begin
          state_nx_s = ST_TRAP;
          cause_nx_s = CAUSE_FETCH_FAULT;
        end else if (fetch_done_s) begin
          state_nx_s = ST_DECODE;
        end else begin
          state_nx_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (dec_illegal_s) begin
          state_nx_s = ST_TRAP;
          cause_nx_s = CAUSE_ILLEGAL;
        end else if (dec_class_s == CLS_SYSTEM) begin
          state_nx_s = ST_TRAP;
          cause_nx_s = imm_sys ? CAUSE_BREAKPOINT : CAUSE_ECALL_M;
        end else begin
          state_nx_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (class_r)
          CLS_BRANCH: state_nx_s = ST_FETCH;
          CLS_LOAD,
          CLS_STORE: begin
            if (misalign_s) begin
              state_nx_s = ST_TRAP;
              cause_nx_s = is_load_s ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN;
            end else begin
              state_nx_s = ST_MEM;
            end
          end
          default: state_nx_s = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (timeout_s) begin
          state_nx_s = ST_TRAP;
          cause_nx_s = is_load_s ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT;
        end else if (mem_ready) begin
          state_nx_s = is_load_s ? ST_WB : ST_FETCH;
        end else begin
          state_nx_s = ST_MEM;
        end
      end
      ST_WB: state_nx_s = ST_FETCH;
      ST_TRAP: begin
        if (TRAP_HALT) begin
          state_nx_s = ST_TRAP;
        end else begin
          state_nx_s = ST_FETCH;
          cause_nx_s = 4'd0;
        end
      end
      default: begin
        state_nx_s = ST_FETCH;
        cause_nx_s = 4'd0;
      end
    endcase
  end

  // State, class, cause and wait counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_FETCH;
      class_r    <= CLS_NOP;
      cause_r    <= 4'd0;
      wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      cause_r    <= cause_nx_s;
      class_r    <= (state_r == ST_DECODE) ? dec_class_s : class_r;
      wait_cnt_r <= (waiting_s && !timeout_s) ? wait_cnt_r + 1'b1 : {CNT_W{1'b0}};
    end
  end

  // Moore output decode from state/class, qualified by br_taken/addr_lo/mem_ready
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_wstrb     = 4'b0000;
    load_size     = 2'd0;
    load_unsigned = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = PC_SEL_PC4;
    alu_src_a     = SRC_A_RS1;
    alu_src_b     = SRC_B_RS2;
    alu_op        = ALU_OP_ADD;
    reg_we        = 1'b0;
    wb_sel        = WB_SEL_ALU;
    trap          = 1'b0;
    trap_cause    = 4'd0;
    case (state_r)
      ST_FETCH: begin
        mem_req = fetch_req_s;
        ir_we   = fetch_done_s;
        pc_we   = fetch_done_s;
      end
      ST_EXEC: begin
        alu_src_a = alu_a_s;
        alu_src_b = alu_b_s;
        alu_op    = alu_op_s;
        if (class_r == CLS_BRANCH) begin
          pc_we  = br_taken;
          pc_sel = PC_SEL_BRANCH;
        end else begin
          pc_we  = 1'b0;
          pc_sel = PC_SEL_PC4;
        end
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        alu_src_a = alu_a_s;
        alu_src_b = alu_b_s;
        alu_op    = alu_op_s;
        if (class_r == CLS_STORE) begin
          mem_we    = 1'b1;
          mem_wstrb = store_strobe(funct3, addr_lo);
        end else begin
          load_size     = funct3[1:0];
          load_unsigned = funct3[2];
        end
      end
      ST_WB: begin
        alu_src_a = alu_a_s;
        alu_src_b = alu_b_s;
        alu_op    = alu_op_s;
        reg_we    = (class_r != CLS_NOP);
        case (class_r)
          CLS_LOAD: wb_sel = WB_SEL_LOAD;
          CLS_JAL:  begin wb_sel = WB_SEL_PC4; pc_we = 1'b1; pc_sel = PC_SEL_BRANCH; end
          CLS_JALR: begin wb_sel = WB_SEL_PC4; pc_we = 1'b1; pc_sel = PC_SEL_JALR; end
          default:  wb_sel = WB_SEL_ALU;
        endcase
      end
      ST_TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_r;
        pc_we      = ~TRAP_HALT;
        pc_sel     = TRAP_HALT ? PC_SEL_PC4 : PC_SEL_TRAP;
      end
      default: trap = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rv32i_multicycle_control.sv
// Randomized bench for rv32i_multicycle_control (default parameters). Each
// instruction is expanded by a behavioural model into a list of per-cycle
// phases; every cycle the full output vector is compared to the model.
module tb_rv32i_multicycle_control;

  localparam int MEM_TO = 16;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5,
                 K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_FENCE = 9, K_SYS = 10, K_BAD = 11;

  logic       clk = 1'b0;
  logic       rst, run, funct7_5, imm_sys, br_taken, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [1:0] addr_lo;
  logic       mem_req, mem_we, load_unsigned, ir_we, pc_we, reg_we, trap;
  logic [3:0] mem_wstrb, trap_cause;
  logic [1:0] load_size, pc_sel, alu_src_a, alu_src_b, alu_op, wb_sel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rv32i_multicycle_control dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .imm_sys(imm_sys), .addr_lo(addr_lo), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .load_size(load_size), .load_unsigned(load_unsigned), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_we(reg_we), .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observed();
    return {5'd0, trap_cause, trap, wb_sel, reg_we, alu_op, alu_src_b, alu_src_a,
            pc_sel, pc_we, ir_we, load_unsigned, load_size, mem_wstrb, mem_we, mem_req};
  endfunction

  function automatic int kind_of(input logic [6:0] op);
    case (op)
      7'h33: return K_R;    7'h13: return K_I;     7'h03: return K_LD;
      7'h23: return K_ST;   7'h63: return K_BR;    7'h6F: return K_JAL;
      7'h67: return K_JALR; 7'h37: return K_LUI;   7'h17: return K_AUIPC;
      7'h0F: return K_FENCE; 7'h73: return K_SYS;
      default: return K_BAD;
    endcase
  endfunction

  function automatic bit legal(input int kind, input int f3, input bit f75);
    case (kind)
      K_R:    return !(f75 && f3 != 0 && f3 != 5);
      K_I:    return !(f75 && f3 == 1);
      K_LD:   return f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5;
      K_ST:   return f3 < 3;
      K_BR:   return f3 != 2 && f3 != 3;
      K_JALR, K_SYS, K_FENCE: return f3 == 0;
      K_BAD:  return 0;
      default: return 1;
    endcase
  endfunction

  // Expected output vector for one phase of an instruction
  function automatic logic [31:0] expect_vec(input byte ph, input int kind, input int f3,
                                             input int addr, input bit br, input int cause);
    int req = 0, we = 0, strb = 0, lsz = 0, lun = 0, irw = 0, pcw = 0, pcs = 0;
    int sa = 0, sb = 0, aop = 0, rw = 0, wbs = 0, tr = 0, tc = 0;
    if (ph == "E" || ph == "M" || ph == "m" || ph == "W") begin
      case (kind)
        K_R:                aop = 2;
        K_I:                begin sb = 1; aop = 2; end
        K_LD, K_ST, K_JALR: sb = 1;
        K_BR:               aop = 1;
        K_JAL, K_AUIPC:     begin sa = 1; sb = 1; end
        K_LUI:              begin sa = 2; sb = 1; end
        default:            aop = 0;
      endcase
    end
    case (ph)
      "F": req = 1;
      "f": begin req = 1; irw = 1; pcw = 1; end
      "E": if (kind == K_BR) begin pcw = int'(br); pcs = 1; end
      "M", "m": begin
        req = 1;
        if (kind == K_ST) begin
          we = 1;
          strb = (((1 << (1 << (f3 % 4))) - 1) << addr) & 15;
        end else begin
          lsz = f3 % 4;
          lun = f3 / 4;
        end
      end
      "W": begin
        rw  = (kind != K_FENCE) ? 1 : 0;
        wbs = (kind == K_LD) ? 1 : (kind == K_JAL || kind == K_JALR) ? 2 : 0;
        if (kind == K_JAL)  begin pcw = 1; pcs = 1; end
        if (kind == K_JALR) begin pcw = 1; pcs = 2; end
      end
      "T": begin tr = 1; tc = cause; end
      default: tr = 0;
    endcase
    return {5'd0, 4'(tc), 1'(tr), 2'(wbs), 1'(rw), 2'(aop), 2'(sb), 2'(sa), 2'(pcs),
            1'(pcw), 1'(irw), 1'(lun), 2'(lsz), 4'(strb), 1'(we), 1'(req)};
  endfunction

  // Build the phase list for one instruction, then drive and check each cycle
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic isys, input logic [1:0] addr, input logic br,
                           input int idle, input int fw, input int mw, input string name);
    byte ph[$];
    int  kind, cause, bytes;
    kind  = kind_of(op);
    cause = 0;
    for (int i = 0; i < idle; i++) ph.push_back("I");
    if (fw >= MEM_TO) begin
      repeat (MEM_TO) ph.push_back("F");
      cause = 1;
    end else begin
      repeat (fw) ph.push_back("F");
      ph.push_back("f");
      ph.push_back("D");
      if (!legal(kind, int'(f3), f75)) cause = 2;
      else if (kind == K_SYS) cause = isys ? 3 : 11;
      else begin
        ph.push_back("E");
        bytes = 1 << (int'(f3) % 4);
        if (kind == K_LD || kind == K_ST) begin
          if ((int'(addr) % bytes) != 0) cause = (kind == K_LD) ? 4 : 6;
          else if (mw >= MEM_TO) begin
            repeat (MEM_TO) ph.push_back("M");
            cause = (kind == K_LD) ? 5 : 7;
          end else begin
            repeat (mw) ph.push_back("M");
            ph.push_back("m");
            if (kind == K_LD) ph.push_back("W");
          end
        end else if (kind != K_BR) ph.push_back("W");
      end
    end
    if (cause != 0) repeat (3) ph.push_back("T");

    opcode = op; funct3 = f3; funct7_5 = f75; imm_sys = isys; addr_lo = addr; br_taken = br;
    foreach (ph[i]) begin
      if (ph[i] == "I") run = 1'b0;
      else if (ph[i] == "F" || ph[i] == "f") run = 1'b1;
      else run = 1'($urandom_range(0, 1));
      if (ph[i] == "F" || ph[i] == "M") mem_ready = 1'b0;
      else if (ph[i] == "f" || ph[i] == "m") mem_ready = 1'b1;
      else mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq($sformatf("%s_%0d%c", name, i, ph[i]), observed(),
               expect_vec(ph[i], kind, int'(f3), int'(addr), br, cause));
      @(posedge clk); #1;
    end
    if (cause != 0) begin
      rst = 1'b1; run = 1'($urandom_range(0, 1)); mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      @(negedge clk);
      check_eq({name, "_rst_clear"}, observed(), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  // Reset asserted while a load is waiting in MEM
  task automatic reset_in_mem();
    string seq = "fDEM";
    opcode = 7'h03; funct3 = 3'd2; funct7_5 = 1'b0; imm_sys = 1'b0; addr_lo = 2'd0;
    for (int i = 0; i < 4; i++) begin
      run = 1'b1;
      mem_ready = (i == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
      check_eq($sformatf("rstmem_%0d", i), observed(), expect_vec(seq[i], K_LD, 2, 0, 1'b0, 0));
      @(posedge clk); #1;
    end
    rst = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rstmem_req_drop", observed(), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    check_eq("rstmem_run0_idle", observed(), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [6:0] ops [13] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                           7'h37, 7'h17, 7'h0F, 7'h73, 7'h00, 7'h7F};

  initial begin
    int fw, mw, r;
    logic [2:0] f3;
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = 7'h00; funct3 = 3'd0;
    funct7_5 = 1'b0; imm_sys = 1'b0; addr_lo = 2'd0; br_taken = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check_eq("reset_state", observed(), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(7'h33, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 0, "add");
    run_instr(7'h03, 3'd2, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 3, "lw_wait3");
    run_instr(7'h23, 3'd0, 1'b0, 1'b0, 2'd2, 1'b0, 0, 0, 0, "sb_a2");
    run_instr(7'h23, 3'd1, 1'b0, 1'b0, 2'd1, 1'b0, 0, 0, 0, "sh_mis");
    run_instr(7'h63, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 0, 0, 0, "beq_t");
    run_instr(7'h63, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 0, "beq_nt");
    run_instr(7'h33, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 16, 0, "fetch_to");
    run_instr(7'h00, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 0, "op00");
    run_instr(7'h73, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 0, "ecall");
    run_instr(7'h73, 3'd0, 1'b0, 1'b1, 2'd0, 1'b0, 0, 0, 0, "ebreak");
    run_instr(7'h6F, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 0, "jal");
    run_instr(7'h67, 3'd0, 1'b0, 1'b0, 2'd3, 1'b0, 0, 1, 0, "jalr");
    run_instr(7'h03, 3'd4, 1'b0, 1'b0, 2'd3, 1'b0, 0, 0, 20, "lbu_to");
    run_instr(7'h23, 3'd2, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 16, "sw_to");
    run_instr(7'h03, 3'd5, 1'b0, 1'b0, 2'd2, 1'b0, 0, 0, 15, "lhu_w15");
    run_instr(7'h0F, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 0, "fence");
    run_instr(7'h37, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3, 0, 0, "lui_run0");
    reset_in_mem();
    run_instr(7'h17, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 0, "auipc_after_rst");

    for (int n = 0; n < 250; n++) begin
      r  = $urandom_range(0, 29);
      fw = (r == 0) ? 16 + $urandom_range(0, 4) : (r == 1) ? 15 : $urandom_range(0, 3);
      r  = $urandom_range(0, 29);
      mw = (r == 0) ? 16 + $urandom_range(0, 4) : (r == 1) ? 15 : $urandom_range(0, 3);
      f3 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      run_instr(ops[$urandom_range(0, 12)], f3, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, fw, mw,
                $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
